// File: rtl/hazard_control_unit_if.sv
// Pipeline hazard control bus.
// Carries the hazard-detection inputs (load in EXE, register numbers in ID,
// branch outcome, data-memory handshake) toward the control unit, and the
// pipeline-register enables, flush/bubble controls, counters and state back.
// master: pipeline side (drives hazard inputs, receives controls)
// slave : hazard_control_unit (receives hazard inputs, drives controls)
interface hazard_control_unit_if;
  logic        ID_EXE_MemRd;
  logic [2:0]  ID_EXE_rt;
  logic [2:0]  IF_ID_rs;
  logic [2:0]  IF_ID_rt;
  logic        IF_ID_UseRt;
  logic        EXE_BrTaken;
  logic        MEM_Req;
  logic        MEM_Ready;
  logic        PC_Wr;
  logic        IF_ID_Wr;
  logic        IF_ID_Flush;
  logic        ID_EXE_Bubble;
  logic        EXE_MEM_Wr;
  logic        MEM_WB_Wr;
  logic [15:0] StallCnt;
  logic [15:0] FlushCnt;
  logic [1:0]  State;

  modport master (
    output ID_EXE_MemRd, ID_EXE_rt, IF_ID_rs, IF_ID_rt, IF_ID_UseRt,
           EXE_BrTaken, MEM_Req, MEM_Ready,
    input  PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EXE_Bubble, EXE_MEM_Wr,
           MEM_WB_Wr, StallCnt, FlushCnt, State
  );

  modport slave (
    input  ID_EXE_MemRd, ID_EXE_rt, IF_ID_rs, IF_ID_rt, IF_ID_UseRt,
           EXE_BrTaken, MEM_Req, MEM_Ready,
    output PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EXE_Bubble, EXE_MEM_Wr,
           MEM_WB_Wr, StallCnt, FlushCnt, State
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard control unit for a 5-stage pipeline.
// Resolves memory freeze, taken-branch flush and load-use stall with priority
// freeze > branch > load-use. Controls are Mealy (combinational from state
// and inputs). Saturating counters track stall and flush cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; forces RUN, zero counters and
//          all controls low while asserted
//   bus  - hazard_control_unit_if.slave (hazard inputs in, controls out)
module hazard_control_unit (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave bus
);

  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MEMWAIT = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic hazard;
  logic hazard_blocked;
  logic illegal_state;
  logic pc_wr, if_id_wr, if_id_flush, id_exe_bubble, exe_mem_wr, mem_wb_wr;

  // Hazard conditions; register 0 is not special here.
  always_comb begin
    freeze = bus.MEM_Req & ~bus.MEM_Ready;
    hazard = bus.ID_EXE_MemRd &
             ((bus.ID_EXE_rt == bus.IF_ID_rs) |
              (bus.IF_ID_UseRt & (bus.ID_EXE_rt == bus.IF_ID_rt)));
  end

  // Next state and Mealy controls.
  always_comb begin
    pc_wr          = 1'b1;
    if_id_wr       = 1'b1;
    if_id_flush    = 1'b0;
    id_exe_bubble  = 1'b0;
    exe_mem_wr     = 1'b1;
    mem_wb_wr      = 1'b1;
    state_d        = RUN;
    hazard_blocked = 1'b0;
    illegal_state  = 1'b0;

    case (state_q)
      RUN, MEMWAIT: hazard_blocked = 1'b0;
      // The stalled load has moved on; one bubble per load-use is enough.
      LDSTALL:      hazard_blocked = 1'b1;
      default:      illegal_state  = 1'b1;
    endcase

    if (freeze) begin
      pc_wr      = 1'b0;
      if_id_wr   = 1'b0;
      exe_mem_wr = 1'b0;
      mem_wb_wr  = 1'b0;
      state_d    = MEMWAIT;
    end else if (bus.EXE_BrTaken) begin
      if_id_flush   = 1'b1;
      id_exe_bubble = 1'b1;
      state_d       = RUN;
    end else if (hazard && !hazard_blocked) begin
      pc_wr         = 1'b0;
      if_id_wr      = 1'b0;
      id_exe_bubble = 1'b1;
      state_d       = LDSTALL;
    end

    if (illegal_state) begin
      state_d = RUN;
    end

    // Reset holds every control low independent of the clock.
    if (rst) begin
      pc_wr         = 1'b0;
      if_id_wr      = 1'b0;
      if_id_flush   = 1'b0;
      id_exe_bubble = 1'b0;
      exe_mem_wr    = 1'b0;
      mem_wb_wr     = 1'b0;
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_wr && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (if_id_flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PC_Wr         = pc_wr;
  assign bus.IF_ID_Wr      = if_id_wr;
  assign bus.IF_ID_Flush   = if_id_flush;
  assign bus.ID_EXE_Bubble = id_exe_bubble;
  assign bus.EXE_MEM_Wr    = exe_mem_wr;
  assign bus.MEM_WB_Wr     = mem_wb_wr;
  assign bus.StallCnt      = stall_cnt_q;
  assign bus.FlushCnt      = flush_cnt_q;
  assign bus.State         = state_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_hazard_control_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_control_unit_if bus();

  hazard_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which situation the pipeline is in, plus event tallies.
  localparam int M_RUN = 0, M_LD = 1, M_WAIT = 2;
  int m_state;
  int m_stall;
  int m_flush;

  task automatic drive(input bit memrd, input logic [2:0] exrt,
                       input logic [2:0] rs, input logic [2:0] rt,
                       input bit usert, input bit br, input bit req,
                       input bit rdy);
    bus.ID_EXE_MemRd = memrd;
    bus.ID_EXE_rt    = exrt;
    bus.IF_ID_rs     = rs;
    bus.IF_ID_rt     = rt;
    bus.IF_ID_UseRt  = usert;
    bus.EXE_BrTaken  = br;
    bus.MEM_Req      = req;
    bus.MEM_Ready    = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
  endtask

  function automatic logic [5:0] enables();
    return {bus.PC_Wr, bus.IF_ID_Wr, bus.IF_ID_Flush, bus.ID_EXE_Bubble,
            bus.EXE_MEM_Wr, bus.MEM_WB_Wr};
  endfunction

  // Expected {PC,IFID,Flush,Bubble,EXMEM,MEMWB} and next situation.
  function automatic void ref_eval(input int st, output logic [5:0] o,
                                   output int nx);
    bit frz;
    bit hz;
    frz = bus.MEM_Req && !bus.MEM_Ready;
    hz  = bus.ID_EXE_MemRd && ((bus.ID_EXE_rt == bus.IF_ID_rs) ||
          (bus.IF_ID_UseRt && (bus.ID_EXE_rt == bus.IF_ID_rt)));
    if (frz) begin
      o = 6'b000000; nx = M_WAIT;
    end else if (bus.EXE_BrTaken) begin
      o = 6'b111111; nx = M_RUN;
    end else if (hz && st != M_LD) begin
      o = 6'b000111; nx = M_LD;
    end else begin
      o = 6'b110011; nx = M_RUN;
    end
  endfunction

  task automatic test_reset();
    apply_reset();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc();
    drive(1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    total++;
    if (enables() !== 6'b000000) begin
      bad++; $display("FAIL reset_enables: got %b want 000000", enables());
    end
    total++;
    if (bus.State !== 2'b00) begin
      bad++; $display("FAIL reset_state: got %b want 00", bus.State);
    end
    total++;
    if (bus.StallCnt !== 16'd0 || bus.FlushCnt !== 16'd0) begin
      bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0",
                      bus.StallCnt, bus.FlushCnt);
    end
    cyc();
    rst = 1'b0;
    idle();
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    total++;
    if ({bus.PC_Wr, bus.IF_ID_Wr, bus.ID_EXE_Bubble} !== 3'b001) begin
      bad++; $display("FAIL lu_cycle0: got %b want 001",
                      {bus.PC_Wr, bus.IF_ID_Wr, bus.ID_EXE_Bubble});
    end
    cyc();
    total++;
    if (bus.State !== 2'b01) begin
      bad++; $display("FAIL lu_state1: got %b want 01", bus.State);
    end
    #2;
    total++;
    if ({bus.PC_Wr, bus.ID_EXE_Bubble} !== 2'b10) begin
      bad++; $display("FAIL lu_cycle1: got %b want 10",
                      {bus.PC_Wr, bus.ID_EXE_Bubble});
    end
    cyc();
    total++;
    if (bus.State !== 2'b00 || bus.StallCnt !== 16'd1) begin
      bad++; $display("FAIL lu_end: got state %b stall %0d want 00 1",
                      bus.State, bus.StallCnt);
    end
    idle();
  endtask

  task automatic test_rt_only();
    apply_reset();
    drive(1'b1, 3'd5, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    total++;
    if (bus.PC_Wr !== 1'b1) begin
      bad++; $display("FAIL rt_nouse_pc: got %b want 1", bus.PC_Wr);
    end
    cyc();
    drive(1'b1, 3'd5, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    total++;
    if (bus.PC_Wr !== 1'b0 || bus.ID_EXE_Bubble !== 1'b1) begin
      bad++; $display("FAIL rt_use_stall: got pc %b bub %b want 0 1",
                      bus.PC_Wr, bus.ID_EXE_Bubble);
    end
    cyc();
    #2;
    total++;
    if (bus.PC_Wr !== 1'b1) begin
      bad++; $display("FAIL rt_use_release: got %b want 1", bus.PC_Wr);
    end
    cyc();
    total++;
    if (bus.StallCnt !== 16'd1) begin
      bad++; $display("FAIL rt_stallcnt: got %0d want 1", bus.StallCnt);
    end
    idle();
  endtask

  task automatic test_mem_wait();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      #2;
      total++;
      if (enables() !== 6'b000000) begin
        bad++; $display("FAIL mw_enables_%0d: got %b want 000000", i, enables());
      end
      cyc();
      total++;
      if (bus.State !== 2'b10) begin
        bad++; $display("FAIL mw_state_%0d: got %b want 10", i, bus.State);
      end
    end
    total++;
    if (bus.StallCnt !== 16'd4) begin
      bad++; $display("FAIL mw_stallcnt: got %0d want 4", bus.StallCnt);
    end
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    total++;
    if (enables() !== 6'b110011) begin
      bad++; $display("FAIL mw_exit_enables: got %b want 110011", enables());
    end
    cyc();
    total++;
    if (bus.State !== 2'b00 || bus.StallCnt !== 16'd4) begin
      bad++; $display("FAIL mw_exit: got state %b stall %0d want 00 4",
                      bus.State, bus.StallCnt);
    end
    idle();
  endtask

  task automatic test_priority();
    apply_reset();
    drive(1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    total++;
    if (enables() !== 6'b111111) begin
      bad++; $display("FAIL pri_branch: got %b want 111111", enables());
    end
    cyc();
    total++;
    if (bus.FlushCnt !== 16'd1 || bus.State !== 2'b00) begin
      bad++; $display("FAIL pri_branch_after: got flush %0d state %b want 1 00",
                      bus.FlushCnt, bus.State);
    end
    drive(1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    total++;
    if (enables() !== 6'b000000) begin
      bad++; $display("FAIL pri_freeze: got %b want 000000", enables());
    end
    cyc();
    total++;
    if (bus.FlushCnt !== 16'd1 || bus.State !== 2'b10) begin
      bad++; $display("FAIL pri_freeze_after: got flush %0d state %b want 1 10",
                      bus.FlushCnt, bus.State);
    end
    idle();
  endtask

  task automatic test_random();
    logic [5:0] exp_o;
    int         nx;
    apply_reset();
    m_state = M_RUN;
    m_stall = 0;
    m_flush = 0;
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      #2;
      ref_eval(m_state, exp_o, nx);
      total++;
      if (enables() !== exp_o) begin
        bad++; $display("FAIL rnd_enables_%0d: got %b want %b", i, enables(), exp_o);
      end
      cyc();
      if (!exp_o[5]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (exp_o[3])  m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      m_state = nx;
      total++;
      if (bus.State !== 2'(m_state) || bus.StallCnt !== 16'(m_stall) ||
          bus.FlushCnt !== 16'(m_flush)) begin
        bad++; $display("FAIL rnd_regs_%0d: got %b/%0d/%0d want %0d/%0d/%0d", i,
                        bus.State, bus.StallCnt, bus.FlushCnt, m_state, m_stall,
                        m_flush);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc();
    total++;
    if (bus.State !== 2'b10) begin
      bad++; $display("FAIL ar_in_wait: got %b want 10", bus.State);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.State !== 2'b00 || bus.StallCnt !== 16'd0 ||
        bus.FlushCnt !== 16'd0 || enables() !== 6'b000000) begin
      bad++; $display("FAIL ar_wait_reset: got %b/%0d/%0d/%b want 00/0/0/000000",
                      bus.State, bus.StallCnt, bus.FlushCnt, enables());
    end
    #2 rst = 1'b0;
    // Enter LDSTALL, then reset mid-cycle and confirm a fresh stall from RUN.
    drive(1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    total++;
    if (bus.State !== 2'b01) begin
      bad++; $display("FAIL ar_in_ld: got %b want 01", bus.State);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.State !== 2'b00) begin
      bad++; $display("FAIL ar_ld_reset: got %b want 00", bus.State);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (bus.PC_Wr !== 1'b0 || bus.ID_EXE_Bubble !== 1'b1) begin
      bad++; $display("FAIL ar_first_from_run: got pc %b bub %b want 0 1",
                      bus.PC_Wr, bus.ID_EXE_Bubble);
    end
    cyc();
    idle();
  endtask

  task automatic test_saturation();
    apply_reset();
    drive(1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    total++;
    if (bus.StallCnt !== 16'hFFFE) begin
      bad++; $display("FAIL sat_preload: got %h want fffe", bus.StallCnt);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (bus.StallCnt !== 16'hFFFF) begin
        bad++; $display("FAIL sat_hold_%0d: got %h want ffff", i, bus.StallCnt);
      end
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_rt_only();
    test_mem_wait();
    test_priority();
    test_random();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
